count_stream_decoder: RTL and testbench
=======================================

Name: count_stream_decoder

Overview:
- Receive-side partner of the mod-16 up/down counter. Samples the counter's 4-bit count bus on clkout and decodes it into direction, step, wrap and jump (preload) events.
- Tracks lock status with a small FSM. Accumulates a saturating step tally for status/display logic downstream.
- Sits on the same divided clock domain (clkout) as the counter it observes.

Parameters:
- WIDTH, 4, width of observed count bus; legal range >= 2 (+1 and -1 must differ).
- STEP_W, 8, width of step accumulator.
- JUMP_LIMIT, 3, consecutive jumps in LOCKED before entering LOST; legal range 1..15.

Ports:
- clkout  in  1  sampling clock, rising edge active.
- reset  in  1  asynchronous, active-low reset.
- cnt_in  in  WIDTH  observed count value.
- cnt_valid  in  1  cnt_in is meaningful this edge.
- steps_clr  in  1  synchronous clear of steps.
- dir_up  out  1  1 = counting up, 0 = counting down (meaningful when dir_valid).
- dir_valid  out  1  direction known (state LOCKED).
- step_pulse  out  1  one-cycle pulse: legal +/-1 step seen in LOCKED.
- wrap_pulse  out  1  one-cycle pulse: max->0 (up) or 0->max (down) step.
- jump_pulse  out  1  one-cycle pulse: non-adjacent change (preload) seen in LOCKED.
- dir_change_pulse  out  1  one-cycle pulse: direction flipped while LOCKED.
- steps  out  STEP_W  saturating count of legal steps while LOCKED.
- lost  out  1  state LOST.
- state  out  2  EMPTY=0, ACQUIRE=1, LOCKED=2, LOST=3.

Behaviour:
- Reset (reset=0, async) clears all of the following:
  - state=EMPTY.
  - prev=0, jump_cnt=0, rec_cnt=0.
  - All outputs 0, including dir_up=0 and steps=0.
- Sampling: only on rising clkout edges with cnt_valid=1.
  - cnt_valid=0: prev, state and steps hold; all pulses 0.
- Classification, modulo 2^WIDTH, against prev:
  - UP: cnt_in==prev+1.
  - DOWN: cnt_in==prev-1.
  - HOLD: cnt_in==prev.
  - JUMP: anything else.
  - prev<=cnt_in on every valid sample, in every state.
- All outputs are registered. Pulses assert at the sampling edge and last exactly one clkout period.
- EMPTY:
  - First valid sample stores prev -> ACQUIRE. No classification, no pulses.
- ACQUIRE:
  - UP/DOWN: set dir_up -> LOCKED. No step/wrap pulse on the acquiring edge.
  - HOLD/JUMP: stay in ACQUIRE.
- LOCKED (dir_valid=1):
  - UP/DOWN:
    - step_pulse=1; steps+1, saturating at 2^STEP_W-1; jump_cnt=0.
    - dir_up updated. dir_change_pulse=1 if the new direction differs from the old one.
    - wrap_pulse=1 if UP with prev=max, or DOWN with prev=0.
  - HOLD: no pulses, no counter change. jump_cnt unchanged.
  - JUMP:
    - jump_pulse=1; jump_cnt+1.
    - If jump_cnt reaches JUMP_LIMIT -> LOST, dir_valid=0, jump_cnt=0.
    - Otherwise stay LOCKED, direction retained.
- LOST (lost=1, dir_valid=0):
  - Requires 2 consecutive valid samples classified in the same direction (rec_cnt) -> LOCKED.
    - dir_up is set to that direction.
    - No pulses on the relocking edge.
  - JUMP or opposite direction: rec_cnt restarts (opposite direction counts as 1).
  - HOLD: rec_cnt holds.
- steps_clr=1: steps<=0 at the edge. Takes priority over a simultaneous increment (result 0). Independent of cnt_valid.
- No pulses are generated outside LOCKED (except the transitions defined above). steps only changes in LOCKED or by clear.
- Reset mid-operation: immediate return to EMPTY. The next valid sample is treated as first-sample.

Test Plan:
- Reset, then cnt_in 3,4,5,6 valid:
  - state EMPTY->ACQUIRE->LOCKED on edges 1,2.
  - dir_up=1.
  - step_pulse on edges 3,4; steps=2.
- LOCKED up, feed 14,15,0,1:
  - wrap_pulse exactly on the 15->0 edge; steps+3.
  - Then feed 0,15: dir_change_pulse on the 1->0 edge; wrap_pulse on the 0->15 edge; dir_up=0.
- LOCKED, feed 5 then preload 11:
  - jump_pulse=1, still LOCKED.
  - Then 12: step_pulse, jump_cnt cleared.
- LOCKED, feed 2,9,4,13 (3 jumps, JUMP_LIMIT=3):
  - lost=1, state=3 after the third jump.
  - Then 14,15: relock on the second step, dir_up=1, no pulses on the relock edge.
- Interleave cnt_valid=0 cycles and repeated values (7,7,7,8):
  - No pulses during cnt_valid=0 or HOLD.
  - Single step_pulse at 7->8.
- steps saturation and clear:
  - STEP_W=8, 300 UP steps -> steps=255.
  - steps_clr asserted together with a step -> steps=0.
  - Async reset asserted mid-stream -> all outputs 0 immediately, state=0.

Source files
------------

// File: rtl/count_stream_decoder.sv
// count_stream_decoder
// ---------------------------------------------------------------------------
// Receive-side partner of a mod-2^WIDTH up/down counter. On each rising
// clkout edge where cnt_valid is high, the observed count is classified
// against the previous valid sample as UP (+1), DOWN (-1), HOLD (same) or
// JUMP (anything else, e.g. a preload). A small FSM tracks lock on the
// counting direction. Event pulses and a saturating step tally are derived
// from that classification.
//
// Ports
//   clkout            in   sampling clock, rising edge active
//   reset             in   asynchronous, active-low reset
//   cnt_in[WIDTH]     in   observed count value
//   cnt_valid         in   cnt_in is meaningful on this edge
//   steps_clr         in   synchronous clear of steps (wins over increment)
//   dir_up            out  1 = counting up, 0 = down (meaningful when dir_valid)
//   dir_valid         out  direction known (state LOCKED)
//   step_pulse        out  legal +/-1 step seen in LOCKED
//   wrap_pulse        out  max->0 (up) or 0->max (down) step in LOCKED
//   jump_pulse        out  non-adjacent change seen in LOCKED
//   dir_change_pulse  out  direction flipped while LOCKED
//   steps[STEP_W]     out  saturating count of legal steps while LOCKED
//   lost              out  state LOST
//   state[2]          out  FSM state: EMPTY=0, ACQUIRE=1, LOCKED=2, LOST=3
//
// Handshake: cnt_valid qualifies cnt_in for exactly the edge at which it is
// sampled high. There is no backpressure; every valid edge is consumed, and
// edges with cnt_valid low leave prev, state and steps untouched.
//
// All outputs come straight from flops. Pulses are set at the sampling edge
// and cleared at the next edge, so they last exactly one clkout period.
// ---------------------------------------------------------------------------
module count_stream_decoder #(
  parameter int WIDTH      = 4,
  parameter int STEP_W     = 8,
  parameter int JUMP_LIMIT = 3
) (
  input  logic              clkout,
  input  logic              reset,
  input  logic [WIDTH-1:0]  cnt_in,
  input  logic              cnt_valid,
  input  logic              steps_clr,
  output logic              dir_up,
  output logic              dir_valid,
  output logic              step_pulse,
  output logic              wrap_pulse,
  output logic              jump_pulse,
  output logic              dir_change_pulse,
  output logic [STEP_W-1:0] steps,
  output logic              lost,
  output logic [1:0]        state
);

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_LOCKED  = 2'd2,
    ST_LOST    = 2'd3
  } state_t;

  // Two consecutive same-direction steps are needed to leave LOST.
  localparam logic [1:0] RELOCK_N = 2'd2;

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  state_t              state_q,    state_d;
  logic [WIDTH-1:0]    prev_q,     prev_d;
  logic [3:0]          jump_cnt_q, jump_cnt_d;
  logic [1:0]          rec_cnt_q,  rec_cnt_d;
  logic                rec_dir_q,  rec_dir_d;
  logic                dir_up_q,   dir_up_d;
  logic                dir_valid_q, dir_valid_d;
  logic                lost_q,     lost_d;
  logic                step_q,     step_d;
  logic                wrap_q,     wrap_d;
  logic                jump_q,     jump_d;
  logic                chg_q,      chg_d;
  logic [STEP_W-1:0]   steps_q,    steps_d;

  // ---------------------------------------------------------------------------
  // Classification of the incoming sample against prev (modulo 2^WIDTH)
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] prev_inc;
  logic [WIDTH-1:0] prev_dec;
  logic             is_up;
  logic             is_down;
  logic             is_hold;
  logic             is_jump;
  logic             is_step;
  logic             prev_is_max;
  logic             prev_is_zero;

  assign prev_inc     = prev_q + WIDTH'(1);
  assign prev_dec     = prev_q - WIDTH'(1);
  assign is_up        = (cnt_in == prev_inc);
  assign is_down      = (cnt_in == prev_dec);
  assign is_hold      = (cnt_in == prev_q);
  assign is_step      = is_up | is_down;
  assign is_jump      = ~(is_step | is_hold);
  assign prev_is_max  = (prev_q == {WIDTH{1'b1}});
  assign prev_is_zero = (prev_q == '0);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clkout or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_EMPTY;
      prev_q      <= '0;
      jump_cnt_q  <= '0;
      rec_cnt_q   <= '0;
      rec_dir_q   <= 1'b0;
      dir_up_q    <= 1'b0;
      dir_valid_q <= 1'b0;
      lost_q      <= 1'b0;
      step_q      <= 1'b0;
      wrap_q      <= 1'b0;
      jump_q      <= 1'b0;
      chg_q       <= 1'b0;
      steps_q     <= '0;
    end else begin
      state_q     <= state_d;
      prev_q      <= prev_d;
      jump_cnt_q  <= jump_cnt_d;
      rec_cnt_q   <= rec_cnt_d;
      rec_dir_q   <= rec_dir_d;
      dir_up_q    <= dir_up_d;
      dir_valid_q <= dir_valid_d;
      lost_q      <= lost_d;
      step_q      <= step_d;
      wrap_q      <= wrap_d;
      jump_q      <= jump_d;
      chg_q       <= chg_d;
      steps_q     <= steps_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and next-output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    prev_d     = prev_q;
    jump_cnt_d = jump_cnt_q;
    rec_cnt_d  = rec_cnt_q;
    rec_dir_d  = rec_dir_q;
    dir_up_d   = dir_up_q;
    step_d     = 1'b0;
    wrap_d     = 1'b0;
    jump_d     = 1'b0;
    chg_d      = 1'b0;
    steps_d    = steps_q;

    if (cnt_valid) begin
      // prev tracks every valid sample regardless of state.
      prev_d = cnt_in;

      unique case (state_q)
        ST_EMPTY: begin
          // Nothing to compare against yet.
          state_d = ST_ACQUIRE;
        end

        ST_ACQUIRE: begin
          // The first adjacent step establishes the direction; it is not
          // itself reported as a step.
          if (is_step) begin
            dir_up_d   = is_up;
            jump_cnt_d = '0;
            state_d    = ST_LOCKED;
          end
        end

        ST_LOCKED: begin
          if (is_step) begin
            step_d     = 1'b1;
            jump_cnt_d = '0;
            dir_up_d   = is_up;
            chg_d      = (is_up != dir_up_q);
            wrap_d     = (is_up & prev_is_max) | (is_down & prev_is_zero);
            if (steps_q != {STEP_W{1'b1}}) begin
              steps_d = steps_q + STEP_W'(1);
            end
          end else if (is_jump) begin
            jump_d = 1'b1;
            // The jump that brings the run up to JUMP_LIMIT drops the lock.
            if (jump_cnt_q == 4'(JUMP_LIMIT - 1)) begin
              jump_cnt_d = '0;
              rec_cnt_d  = '0;
              state_d    = ST_LOST;
            end else begin
              jump_cnt_d = jump_cnt_q + 4'd1;
            end
          end
          // HOLD: nothing changes.
        end

        ST_LOST: begin
          if (is_step) begin
            if ((rec_cnt_q != '0) && (rec_dir_q == is_up)) begin
              if (rec_cnt_q + 2'd1 == RELOCK_N) begin
                // Relock silently in the observed direction.
                dir_up_d   = is_up;
                rec_cnt_d  = '0;
                jump_cnt_d = '0;
                state_d    = ST_LOCKED;
              end else begin
                rec_cnt_d = rec_cnt_q + 2'd1;
              end
            end else begin
              // First step of a run, or a reversal: this step starts a new run.
              rec_cnt_d = 2'd1;
              rec_dir_d = is_up;
            end
          end else if (is_jump) begin
            rec_cnt_d = '0;
          end
          // HOLD: recovery run is neither broken nor advanced.
        end

        default: begin
          state_d = ST_EMPTY;
        end
      endcase
    end

    // Clear is independent of cnt_valid and overrides a same-edge increment.
    if (steps_clr) begin
      steps_d = '0;
    end
  end

  // Status flags are registered alongside the state they describe.
  assign dir_valid_d = (state_d == ST_LOCKED);
  assign lost_d      = (state_d == ST_LOST);

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign state            = state_q;
  assign dir_up           = dir_up_q;
  assign dir_valid        = dir_valid_q;
  assign lost             = lost_q;
  assign step_pulse       = step_q;
  assign wrap_pulse       = wrap_q;
  assign jump_pulse       = jump_q;
  assign dir_change_pulse = chg_q;
  assign steps            = steps_q;

endmodule

// File: tb/tb_count_stream_decoder.sv
// tb_count_stream_decoder
// ---------------------------------------------------------------------------
// Bench for count_stream_decoder (WIDTH=4, STEP_W=8, JUMP_LIMIT=3).
// A behavioural reference model predicts the full output vector for every
// driven edge and pushes it to exp_q; each scenario task pops and compares
// after the edge, plus a few fixed expectations at notable points.
// Output vector layout (17 bits):
//   {state[1:0], dir_up, dir_valid, step, wrap, jump, dir_change, lost, steps[7:0]}
// ---------------------------------------------------------------------------
module tb_count_stream_decoder;

  localparam int WIDTH      = 4;
  localparam int STEP_W     = 8;
  localparam int JUMP_LIMIT = 3;
  localparam int MOD        = 1 << WIDTH;
  localparam int STEP_MAX   = (1 << STEP_W) - 1;
  localparam int VW         = 17;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic              clkout;
  logic              reset;
  logic [WIDTH-1:0]  cnt_in;
  logic              cnt_valid;
  logic              steps_clr;
  logic              dir_up;
  logic              dir_valid;
  logic              step_pulse;
  logic              wrap_pulse;
  logic              jump_pulse;
  logic              dir_change_pulse;
  logic [STEP_W-1:0] steps;
  logic              lost;
  logic [1:0]        state;

  initial clkout = 1'b0;
  always #5 clkout = ~clkout;

  count_stream_decoder #(
    .WIDTH(WIDTH), .STEP_W(STEP_W), .JUMP_LIMIT(JUMP_LIMIT)
  ) dut (
    .clkout(clkout),
    .reset(reset),
    .cnt_in(cnt_in),
    .cnt_valid(cnt_valid),
    .steps_clr(steps_clr),
    .dir_up(dir_up),
    .dir_valid(dir_valid),
    .step_pulse(step_pulse),
    .wrap_pulse(wrap_pulse),
    .jump_pulse(jump_pulse),
    .dir_change_pulse(dir_change_pulse),
    .steps(steps),
    .lost(lost),
    .state(state)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard and reference model
  // ---------------------------------------------------------------------------
  logic [VW-1:0] exp_q[$];
  int total;
  int bad;

  int m_state, m_prev, m_jc, m_rc, m_rdir, m_dir, m_steps;

  function automatic logic [VW-1:0] dut_vec();
    return {state, dir_up, dir_valid, step_pulse, wrap_pulse, jump_pulse,
            dir_change_pulse, lost, steps};
  endfunction

  task automatic model_reset();
    m_state = 0; m_prev = 0; m_jc = 0; m_rc = 0; m_rdir = 0; m_dir = 0; m_steps = 0;
    exp_q.delete();
  endtask

  // Predict the outputs after one clkout edge with the given inputs.
  task automatic model_step(input int c, input bit v, input bit clr);
    int d;
    bit p_step, p_wrap, p_jump, p_chg, up;
    logic [VW-1:0] e;
    p_step = 0; p_wrap = 0; p_jump = 0; p_chg = 0;
    if (v) begin
      d  = (c - m_prev + MOD) % MOD;   // 1 = up, MOD-1 = down, 0 = hold
      up = (d == 1);
      case (m_state)
        0: m_state = 1;
        1: if (d == 1 || d == MOD - 1) begin
             m_dir = up; m_state = 2;
           end
        2: if (d == 1 || d == MOD - 1) begin
             p_step = 1;
             p_chg  = (int'(up) != m_dir);
             p_wrap = up ? (m_prev == MOD - 1) : (m_prev == 0);
             m_dir  = up;
             m_jc   = 0;
             if (m_steps < STEP_MAX) m_steps++;
           end else if (d != 0) begin
             p_jump = 1;
             m_jc++;
             if (m_jc >= JUMP_LIMIT) begin m_state = 3; m_jc = 0; m_rc = 0; end
           end
        default: if (d == 1 || d == MOD - 1) begin
             if (m_rc > 0 && m_rdir == int'(up)) m_rc++;
             else begin m_rc = 1; m_rdir = up; end
             if (m_rc == 2) begin m_state = 2; m_dir = up; m_rc = 0; m_jc = 0; end
           end else if (d != 0) m_rc = 0;
      endcase
      m_prev = c;
    end
    if (clr) m_steps = 0;
    e = {2'(m_state), 1'(m_dir), 1'(m_state == 2), p_step, p_wrap, p_jump, p_chg,
         1'(m_state == 3), 8'(m_steps)};
    exp_q.push_back(e);
  endtask

  // ---------------------------------------------------------------------------
  // Driver: apply inputs, record prediction, advance one edge, settle.
  // ---------------------------------------------------------------------------
  task automatic drive(input int c, input bit v, input bit clr);
    cnt_in    = WIDTH'(c);
    cnt_valid = v;
    steps_clr = clr;
    model_step(c, v, clr);
    @(posedge clkout);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    logic [VW-1:0] got;
    reset = 1'b0; cnt_in = '0; cnt_valid = 1'b0; steps_clr = 1'b0;
    model_reset();
    repeat (3) @(posedge clkout);
    #1;
    got = dut_vec();
    total++;
    if (got !== '0) begin
      bad++; $display("FAIL reset_state got=%h exp=%h", got, {VW{1'b0}});
    end
    @(negedge clkout);
    reset = 1'b1;
  endtask

  task automatic test_acquire();
    int seq[4] = '{3, 4, 5, 6};
    logic [VW-1:0] got, exp;
    foreach (seq[i]) begin
      drive(seq[i], 1'b1, 1'b0);
      exp = exp_q.pop_front(); got = dut_vec(); total++;
      if (got !== exp) begin bad++; $display("FAIL acquire[%0d] got=%h exp=%h", i, got, exp); end
      if (i == 0) begin
        total++;
        if (state !== 2'd1) begin bad++; $display("FAIL acquire_edge1 state=%0d exp=1", state); end
      end
      if (i == 1) begin
        total++;
        if (state !== 2'd2 || step_pulse !== 1'b0) begin
          bad++; $display("FAIL acquire_edge2 state=%0d step=%b exp=2/0", state, step_pulse);
        end
      end
    end
    total++;
    if (dir_up !== 1'b1 || steps !== 8'd2) begin
      bad++; $display("FAIL acquire_final dir_up=%b steps=%0d exp=1/2", dir_up, steps);
    end
  endtask

  task automatic test_wrap();
    int seq[6] = '{14, 15, 0, 1, 0, 15};
    bit wrap_exp[6] = '{0, 0, 1, 0, 0, 1};
    bit chg_exp[6]  = '{0, 0, 0, 0, 1, 0};
    logic [VW-1:0] got, exp;
    foreach (seq[i]) begin
      drive(seq[i], 1'b1, 1'b0);
      exp = exp_q.pop_front(); got = dut_vec(); total++;
      if (got !== exp) begin bad++; $display("FAIL wrap[%0d] got=%h exp=%h", i, got, exp); end
      total++;
      if (wrap_pulse !== wrap_exp[i] || dir_change_pulse !== chg_exp[i]) begin
        bad++; $display("FAIL wrap_pulse[%0d] wrap=%b chg=%b exp=%b/%b",
                        i, wrap_pulse, dir_change_pulse, wrap_exp[i], chg_exp[i]);
      end
    end
    total++;
    if (dir_up !== 1'b0 || steps !== 8'd7) begin
      bad++; $display("FAIL wrap_final dir_up=%b steps=%0d exp=0/7", dir_up, steps);
    end
  endtask

  task automatic test_jump();
    int seq[3] = '{5, 11, 12};
    logic [VW-1:0] got, exp;
    foreach (seq[i]) begin
      drive(seq[i], 1'b1, 1'b0);
      exp = exp_q.pop_front(); got = dut_vec(); total++;
      if (got !== exp) begin bad++; $display("FAIL jump[%0d] got=%h exp=%h", i, got, exp); end
      if (i == 1) begin
        total++;
        if (jump_pulse !== 1'b1 || state !== 2'd2) begin
          bad++; $display("FAIL jump_preload jump=%b state=%0d exp=1/2", jump_pulse, state);
        end
      end
    end
    total++;
    if (step_pulse !== 1'b1) begin bad++; $display("FAIL jump_then_step step=%b exp=1", step_pulse); end
  endtask

  task automatic test_lost();
    // 1 is a jump from 12, 2 a step (clears the jump run), then 9,4,13 jump.
    int seq[7] = '{1, 2, 9, 4, 13, 14, 15};
    logic [VW-1:0] got, exp;
    foreach (seq[i]) begin
      drive(seq[i], 1'b1, 1'b0);
      exp = exp_q.pop_front(); got = dut_vec(); total++;
      if (got !== exp) begin bad++; $display("FAIL lost[%0d] got=%h exp=%h", i, got, exp); end
      if (i == 3) begin
        total++;
        if (state !== 2'd2) begin bad++; $display("FAIL lost_early state=%0d exp=2", state); end
      end
      if (i == 4) begin
        total++;
        if (lost !== 1'b1 || state !== 2'd3 || dir_valid !== 1'b0) begin
          bad++; $display("FAIL lost_enter lost=%b state=%0d dv=%b exp=1/3/0", lost, state, dir_valid);
        end
      end
      if (i == 5) begin
        total++;
        if (state !== 2'd3) begin bad++; $display("FAIL lost_one_step state=%0d exp=3", state); end
      end
    end
    total++;
    if (state !== 2'd2 || dir_up !== 1'b1 || step_pulse !== 1'b0 || wrap_pulse !== 1'b0) begin
      bad++; $display("FAIL relock state=%0d dir_up=%b step=%b wrap=%b exp=2/1/0/0",
                      state, dir_up, step_pulse, wrap_pulse);
    end
  endtask

  task automatic test_hold();
    int seq[4] = '{7, 7, 7, 8};
    int steps_before;
    logic [VW-1:0] got, exp;
    foreach (seq[i]) begin
      drive(seq[i], 1'b1, 1'b0);
      exp = exp_q.pop_front(); got = dut_vec(); total++;
      if (got !== exp) begin bad++; $display("FAIL hold[%0d] got=%h exp=%h", i, got, exp); end
      if (i == 3) begin
        total++;
        if (step_pulse !== 1'b1 || steps !== 8'(steps_before + 1)) begin
          bad++; $display("FAIL hold_step step=%b steps=%0d exp=1/%0d", step_pulse, steps, steps_before + 1);
        end
      end else begin
        steps_before = steps;
      end
      // Idle edges carrying arbitrary data between samples.
      repeat ($urandom_range(1, 3)) begin
        drive($urandom_range(0, MOD - 1), 1'b0, 1'b0);
        exp = exp_q.pop_front(); got = dut_vec(); total++;
        if (got !== exp) begin bad++; $display("FAIL hold_idle got=%h exp=%h", got, exp); end
        total++;
        if ({step_pulse, wrap_pulse, jump_pulse, dir_change_pulse} !== 4'b0) begin
          bad++; $display("FAIL idle_pulses got=%b exp=0000",
                          {step_pulse, wrap_pulse, jump_pulse, dir_change_pulse});
        end
      end
    end
  endtask

  task automatic test_saturation();
    logic [VW-1:0] got, exp;
    int c;
    int errs;
    c = m_prev;
    errs = 0;
    for (int i = 0; i < 300; i++) begin
      c = (c + 1) % MOD;
      drive(c, 1'b1, 1'b0);
      exp = exp_q.pop_front(); got = dut_vec(); total++;
      if (got !== exp) begin
        bad++;
        if (errs < 5) $display("FAIL sat[%0d] got=%h exp=%h", i, got, exp);
        errs++;
      end
    end
    total++;
    if (steps !== 8'd255) begin bad++; $display("FAIL sat_value steps=%0d exp=255", steps); end
    c = (c + 1) % MOD;
    drive(c, 1'b1, 1'b1);
    exp = exp_q.pop_front(); got = dut_vec(); total++;
    if (got !== exp) begin bad++; $display("FAIL clr_vec got=%h exp=%h", got, exp); end
    total++;
    if (steps !== 8'd0 || step_pulse !== 1'b1) begin
      bad++; $display("FAIL clr_with_step steps=%0d step=%b exp=0/1", steps, step_pulse);
    end
    drive(c, 1'b0, 1'b0);
    c = (c + 1) % MOD;
    drive(c, 1'b1, 1'b0);
    void'(exp_q.pop_front());
    exp = exp_q.pop_front(); got = dut_vec(); total++;
    if (got !== exp) begin bad++; $display("FAIL after_clr got=%h exp=%h", got, exp); end
  endtask

  task automatic test_random();
    logic [VW-1:0] got, exp;
    int c;
    int kind;
    for (int i = 0; i < 200; i++) begin
      kind = $urandom_range(0, 5);
      case (kind)
        0, 1: c = (m_prev + 1) % MOD;
        2:    c = (m_prev + MOD - 1) % MOD;
        3:    c = m_prev;
        default: c = $urandom_range(0, MOD - 1);
      endcase
      drive(c, ($urandom_range(0, 4) != 0), ($urandom_range(0, 15) == 0));
      exp = exp_q.pop_front(); got = dut_vec(); total++;
      if (got !== exp) begin bad++; $display("FAIL random[%0d] got=%h exp=%h", i, got, exp); end
    end
  endtask

  task automatic test_async_reset();
    logic [VW-1:0] got, exp;
    drive((m_prev + 1) % MOD, 1'b1, 1'b0);
    void'(exp_q.pop_front());
    // Assert between edges; outputs must clear without a clock edge.
    #2;
    reset = 1'b0;
    #1;
    got = dut_vec(); total++;
    if (got !== '0) begin bad++; $display("FAIL async_reset got=%h exp=%h", got, {VW{1'b0}}); end
    model_reset();
    @(negedge clkout);
    reset = 1'b1;
    drive(9, 1'b1, 1'b0);
    exp = exp_q.pop_front(); got = dut_vec(); total++;
    if (got !== exp) begin bad++; $display("FAIL post_reset got=%h exp=%h", got, exp); end
    total++;
    if (state !== 2'd1 || step_pulse !== 1'b0) begin
      bad++; $display("FAIL post_reset_first state=%0d step=%b exp=1/0", state, step_pulse);
    end
    drive(8, 1'b1, 1'b0);
    exp = exp_q.pop_front(); got = dut_vec(); total++;
    if (got !== exp) begin bad++; $display("FAIL post_reset_lock got=%h exp=%h", got, exp); end
  endtask

  // ---------------------------------------------------------------------------
  // Sequence and report
  // ---------------------------------------------------------------------------
  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_acquire();
    test_wrap();
    test_jump();
    test_lost();
    test_hold();
    test_saturation();
    test_random();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Backstop so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
